omem_port_sched: RTL

- Clocked scheduler in front of the output spike/residue memory of the SNN layer.
- Arbitrates write (residue+spike) and read (previous residue) requests from the 5 SPEs onto one memory port.
- Generates each SPE's strided neuron address and counts completed neurons.
- Sequences timestep 1 → timestep 2 → output dump, issuing the end-of-timestep pulse and the dump handshake.

---
 rtl/snn_omem_pkg.sv | 18 +
 rtl/omem_port_sched_if.sv | 31 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/omem_port_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/snn_omem_pkg.sv
// Shared constants and types for the output-memory port scheduler.
// Geometry of the SNN output layer and the SPE array.
package snn_omem_pkg;
  localparam int NUM_SPE     = 5;
  localparam int OUTPUT_SIZE = 21;
  localparam int NEURONS     = OUTPUT_SIZE * OUTPUT_SIZE;
  localparam int SUM_WIDTH   = 13;
  localparam int ADDR_W      = 9;
  localparam int IDX_W       = $clog2(NUM_SPE);

  typedef logic [SUM_WIDTH:0] omem_word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    TS_END = 2'd1,
    DUMP   = 2'd2
  } sched_state_t;
endpackage

// File: rtl/omem_port_sched_if.sv
// SPE request/response bundle plus the single output-memory port.
// master: SPEs and memory model; slave: the scheduler.
interface omem_port_sched_if;
  import snn_omem_pkg::*;

  logic [NUM_SPE-1:0]             req_valid;
  logic [NUM_SPE-1:0]             req_write;
  logic [NUM_SPE*(SUM_WIDTH+1)-1:0] req_wdata;
  logic [NUM_SPE-1:0]             req_ready;
  logic                           rsp_valid;
  logic [IDX_W-1:0]               rsp_id;
  omem_word_t                     rsp_data;
  logic                           mem_en;
  logic                           mem_we;
  logic                           mem_bank;
  logic [ADDR_W-1:0]              mem_addr;
  omem_word_t                     mem_wdata;
  omem_word_t                     mem_rdata;

  modport master (
    output req_valid, req_write, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_id, rsp_data,
    input  mem_en, mem_we, mem_bank, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_id, rsp_data,
    output mem_en, mem_we, mem_bank, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts at rr_ptr.
// Lowest offset from rr_ptr wins.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);
  logic [W:0]   s;
  logic [W-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    s       = '0;
    j       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, rr_ptr} + (W+1)'(i);
      if (s >= (W+1)'(N)) s = s - (W+1)'(N);
      j = s[W-1:0];
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/omem_port_sched.sv
// Output-memory port scheduler: arbitration, strided addressing,
// neuron counting and the timestep-1/timestep-2/dump sequence.
module omem_port_sched
  import snn_omem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  omem_port_sched_if.slave   bus,
  output logic [1:0]         ts_cur,
  output logic               ts_done,
  output logic               dump_req,
  input  logic               dump_ack,
  output logic               err_overflow
);
  localparam int PW = ADDR_W + 1;

  sched_state_t      state;
  logic [PW-1:0]     ptr [NUM_SPE];
  logic [ADDR_W-1:0] wr_count;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_SPE-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  omem_word_t        wdata_a [NUM_SPE];
  logic              grant;
  logic              wr;
  logic              ovf;
  logic              last;
  logic [PW-1:0]     gptr;
  omem_word_t        gdata;
  logic              s1_valid;
  logic              s1_ovf;
  logic [IDX_W-1:0]  s1_id;
  logic              rsp_ovf;

  rr_arbiter #(.N(NUM_SPE), .W(IDX_W)) u_arb (
    .req     (bus.req_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_SPE; i++)
      wdata_a[i] = bus.req_wdata[i*(SUM_WIDTH+1) +: SUM_WIDTH+1];
  end

  assign grant = (state == RUN) && !reset && (bus.req_valid != '0);
  assign bus.req_ready = grant ? gnt : '0;
  assign wr    = bus.req_write[gnt_idx];
  assign gptr  = ptr[gnt_idx];
  assign gdata = wdata_a[gnt_idx];
  assign ovf   = gptr >= PW'(NEURONS);
  assign last  = wr && !ovf && (wr_count == ADDR_W'(NEURONS - 1));

  assign ts_done  = (state == TS_END) && (ts_cur == 2'd1);
  assign dump_req = (state == DUMP);
  // Read data is combinational from the memory, zeroed for overflowed reads.
  assign bus.rsp_data = (bus.rsp_valid && !rsp_ovf) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      ts_cur        <= 2'd1;
      wr_count      <= '0;
      rr_ptr        <= '0;
      err_overflow  <= 1'b0;
      for (int i = 0; i < NUM_SPE; i++) ptr[i] <= PW'(i);
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_bank  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      s1_valid      <= 1'b0;
      s1_ovf        <= 1'b0;
      s1_id         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      rsp_ovf       <= 1'b0;
    end else begin
      bus.mem_en    <= 1'b0;
      s1_valid      <= grant && !wr;
      bus.rsp_valid <= s1_valid;
      if (grant && !wr) begin
        s1_id  <= gnt_idx;
        s1_ovf <= ovf;
      end
      if (s1_valid) begin
        bus.rsp_id <= s1_id;
        rsp_ovf    <= s1_ovf;
      end
      unique case (state)
        RUN: begin
          if (grant) begin
            rr_ptr <= (gnt_idx == IDX_W'(NUM_SPE - 1)) ? '0
                    : gnt_idx + IDX_W'(1);
            bus.mem_en    <= !ovf;
            bus.mem_we    <= wr;
            bus.mem_bank  <= wr && (ts_cur == 2'd2);
            bus.mem_addr  <= gptr[ADDR_W-1:0];
            bus.mem_wdata <= gdata;
            if (ovf) begin
              err_overflow <= 1'b1;
            end else if (wr) begin
              ptr[gnt_idx] <= gptr + PW'(NUM_SPE);
              wr_count     <= wr_count + ADDR_W'(1);
              if (last) state <= TS_END;
            end
          end
        end
        TS_END: begin
          if (ts_cur == 2'd1) begin
            ts_cur   <= 2'd2;
            wr_count <= '0;
            for (int i = 0; i < NUM_SPE; i++) ptr[i] <= PW'(i);
            state    <= RUN;
          end else begin
            state <= DUMP;
          end
        end
        DUMP: begin
          if (dump_ack) begin
            ts_cur   <= 2'd1;
            wr_count <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_SPE; i++) ptr[i] <= PW'(i);
            state    <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
